pong_frame_sequencer: RTL and testbench

Once-per-frame game-state scheduler for Pong. It consumes the 720p timing generator's vsync and runs a fixed multi-cycle update FSM during vertical blank: paddle move, ball move, collision, scoring, then commit. It publishes paddle, ball, score and mode registers atomically, so the pixel renderer sees stable values for the whole active region.

---
 rtl/pong_pkg.sv | 75 +++++++
 rtl/pong_paddle_step.sv | 23 ++
 rtl/pong_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_pong_frame_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong geometry, mode/update-state encodings and game-state structs
package pong_pkg;
    localparam int SCREEN_W     = 1280;
    localparam int SCREEN_H     = 720;
    localparam int PADDLE_W     = 16;
    localparam int PADDLE_H     = 128;
    localparam int PADDLE_X_L   = 64;
    localparam int PADDLE_X_R   = 1200;
    localparam int BALL_SIZE    = 16;
    localparam int PADDLE_SPEED = 8;
    localparam int BALL_SPEED   = 4;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 7;

    localparam int PADDLE_Y_MAX = SCREEN_H - PADDLE_H;
    localparam int PADDLE_Y_C   = PADDLE_Y_MAX / 2;
    localparam int BALL_X_MAX   = SCREEN_W - BALL_SIZE;
    localparam int BALL_Y_MAX   = SCREEN_H - BALL_SIZE;
    localparam int BALL_X_C     = BALL_X_MAX / 2;
    localparam int BALL_Y_C     = BALL_Y_MAX / 2;

    typedef enum logic [1:0] {M_ATTRACT, M_SERVE, M_PLAY, M_OVER} mode_t;
    typedef enum logic [2:0] {U_WAIT, U_PADDLE, U_BALL, U_COLLIDE, U_SCORE, U_COMMIT} ustate_t;

    // Ball coordinates briefly go a few pixels negative, so they are handled as signed.
    typedef logic signed [15:0] coord_t;
    localparam coord_t C_BALL   = coord_t'(BALL_SIZE);
    localparam coord_t C_PH     = coord_t'(PADDLE_H);
    localparam coord_t C_XL     = coord_t'(PADDLE_X_L);
    localparam coord_t C_XL_HIT = coord_t'(PADDLE_X_L + PADDLE_W);
    localparam coord_t C_XR     = coord_t'(PADDLE_X_R);
    localparam coord_t C_XR_END = coord_t'(PADDLE_X_R + PADDLE_W);
    localparam coord_t C_XR_HIT = coord_t'(PADDLE_X_R - BALL_SIZE);
    localparam coord_t C_XMAX   = coord_t'(BALL_X_MAX);
    localparam coord_t C_YMAX   = coord_t'(BALL_Y_MAX);
    localparam coord_t C_BSPD   = coord_t'(BALL_SPEED);
    localparam logic [5:0] SERVE_CNT = 6'(SERVE_FRAMES);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);

    // The part of the game state the renderer sees.
    typedef struct packed {
        logic [15:0] pl;
        logic [15:0] pr;
        logic [15:0] bx;
        logic [15:0] by;
        logic [3:0]  sl;
        logic [3:0]  sr;
        mode_t       mode;
    } view_t;

    // dx: 1 = right, dy: 1 = down.
    typedef struct packed {
        view_t      v;
        logic       dx;
        logic       dy;
        logic [5:0] cnt;
    } game_t;

    localparam view_t VIEW_RESET = '{pl: 16'(PADDLE_Y_C), pr: 16'(PADDLE_Y_C),
                                     bx: 16'(BALL_X_C), by: 16'(BALL_Y_C),
                                     sl: 4'd0, sr: 4'd0, mode: M_ATTRACT};
    localparam game_t GAME_RESET = '{v: VIEW_RESET, dx: 1'b1, dy: 1'b1, cnt: 6'd0};

    // Centre the ball and freeze it for a serve, launching toward dx.
    function automatic game_t serve(game_t g, logic dx);
        game_t s;
        s        = g;
        s.v.bx   = VIEW_RESET.bx;
        s.v.by   = VIEW_RESET.by;
        s.dx     = dx;
        s.v.mode = M_SERVE;
        s.cnt    = SERVE_CNT;
        return s;
    endfunction
endpackage

// File: rtl/pong_paddle_step.sv
// pong_paddle_step: combinational saturating paddle move
// Ports: y (current top y), up/down (buttons), en (movement allowed), y_next (updated top y)
module pong_paddle_step
    import pong_pkg::*;
(
    input  logic [15:0] y,
    input  logic        up,
    input  logic        down,
    input  logic        en,
    output logic [15:0] y_next
);
    localparam logic signed [16:0] SPD  = 17'(PADDLE_SPEED);
    localparam logic signed [16:0] YMAX = 17'(PADDLE_Y_MAX);

    logic signed [16:0] ys, y_up, y_dn;

    assign ys     = $signed({1'b0, y});
    assign y_up   = ys - SPD;
    assign y_dn   = ys + SPD;
    assign y_next = (!en || up == down) ? y :
                    up ? (y_up[16] ? 16'd0 : y_up[15:0]) :
                    (y_dn > YMAX ? YMAX[15:0] : y_dn[15:0]);
endmodule

// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer: once-per-frame Pong game update run during vertical blank
// Ports: clk/reset (sync, active-high); vsync from timing generator; paddle buttons and start;
// published paddle_l_y/paddle_r_y, ball_x/ball_y, score_l/score_r, mode; busy while updating;
// frame_done pulses for one cycle when a new frame state is published.
module pong_frame_sequencer
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        up_l,
    input  logic        down_l,
    input  logic        up_r,
    input  logic        down_r,
    input  logic        start,
    output logic [15:0] paddle_l_y,
    output logic [15:0] paddle_r_y,
    output logic [15:0] ball_x,
    output logic [15:0] ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        frame_done
);
    ustate_t     state_q, state_d;
    game_t       g_q, g_d;
    view_t       pub_q, pub_d;
    logic        vsync_q, frame_done_q, frame_done_d;
    logic        tick, move_en, play, hit_l, hit_r, miss_l, miss_r;
    logic [15:0] pl_next, pr_next;
    coord_t      nx, ny, ny_c, pl_s, pr_s;

    assign tick    = vsync & ~vsync_q;
    assign move_en = g_q.v.mode == M_SERVE || g_q.v.mode == M_PLAY;
    assign play    = g_q.v.mode == M_PLAY;

    pong_paddle_step u_step_l (.y(g_q.v.pl), .up(up_l), .down(down_l), .en(move_en), .y_next(pl_next));
    pong_paddle_step u_step_r (.y(g_q.v.pr), .up(up_r), .down(down_r), .en(move_en), .y_next(pr_next));

    // Collision and miss tests read the shadow ball, which holds the moved position by then.
    assign nx     = $signed(g_q.v.bx);
    assign ny     = $signed(g_q.v.by);
    assign pl_s   = $signed(g_q.v.pl);
    assign pr_s   = $signed(g_q.v.pr);
    assign ny_c   = ny <= 16'sd0 ? 16'sd0 : ny >= C_YMAX ? C_YMAX : ny;
    assign hit_l  = !g_q.dx && nx <= C_XL_HIT && nx + C_BALL > C_XL &&
                    ny_c + C_BALL > pl_s && ny_c < pl_s + C_PH;
    assign hit_r  = g_q.dx && nx + C_BALL >= C_XR && nx < C_XR_END &&
                    ny_c + C_BALL > pr_s && ny_c < pr_s + C_PH;
    assign miss_l = !g_q.dx && nx <= 16'sd0;
    assign miss_r = g_q.dx && nx >= C_XMAX;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        pub_d        = pub_q;
        frame_done_d = 1'b0;
        case (state_q)
            U_WAIT: state_d = tick ? U_PADDLE : U_WAIT;
            U_PADDLE: begin
                state_d  = U_BALL;
                g_d.v.pl = pl_next;
                g_d.v.pr = pr_next;
                if ((g_q.v.mode == M_ATTRACT || g_q.v.mode == M_OVER) && start) begin
                    g_d      = serve(g_d, 1'b1);
                    g_d.dy   = 1'b1;
                    g_d.v.sl = 4'd0;
                    g_d.v.sr = 4'd0;
                end
            end
            U_BALL: begin
                state_d = U_COLLIDE;
                if (g_d.v.mode == M_PLAY) begin
                    g_d.v.bx = nx + (g_q.dx ? C_BSPD : -C_BSPD);
                    g_d.v.by = ny + (g_q.dy ? C_BSPD : -C_BSPD);
                end else if (g_q.v.mode == M_SERVE) begin
                    g_d.cnt = g_q.cnt - 6'd1;
                    if (g_q.cnt == 6'd1)
                        g_d.v.mode = M_PLAY;
                end
            end
            U_COLLIDE: begin
                state_d = U_SCORE;
                if (play) begin
                    g_d.v.by = ny_c;
                    g_d.dy   = ny <= 16'sd0 ? 1'b1 : ny >= C_YMAX ? 1'b0 : g_q.dy;
                    g_d.v.bx = hit_l ? C_XL_HIT : hit_r ? C_XR_HIT : nx;
                    g_d.dx   = hit_l | (g_q.dx & ~hit_r);
                end
            end
            U_SCORE: begin
                state_d = U_COMMIT;
                // Serve goes toward whoever conceded the point.
                if (play && (miss_l || miss_r)) begin
                    g_d      = serve(g_q, miss_r);
                    g_d.v.sr = g_q.v.sr + 4'(miss_l);
                    g_d.v.sl = g_q.v.sl + 4'(miss_r);
                    if (g_d.v.sr == WIN || g_d.v.sl == WIN)
                        g_d.v.mode = M_OVER;
                end
            end
            U_COMMIT: begin
                state_d      = U_WAIT;
                pub_d        = g_q.v;
                frame_done_d = 1'b1;
            end
            default: state_d = U_WAIT;
        endcase
    end

    // vsync_q tracks vsync through reset so a level held high across release is not an edge.
    always_ff @(posedge clk) begin
        vsync_q <= vsync;
        if (reset) begin
            state_q      <= U_WAIT;
            g_q          <= GAME_RESET;
            pub_q        <= VIEW_RESET;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            pub_q        <= pub_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign paddle_l_y = pub_q.pl;
    assign paddle_r_y = pub_q.pr;
    assign ball_x     = pub_q.bx;
    assign ball_y     = pub_q.by;
    assign score_l    = pub_q.sl;
    assign score_r    = pub_q.sr;
    assign mode       = pub_q.mode;
    assign busy       = state_q != U_WAIT;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pong_frame_sequencer.sv
// tb_pong_frame_sequencer: random frames against a per-frame game model
module tb_pong_frame_sequencer;
    logic clk = 1'b0;
    logic reset, vsync, up_l, down_l, up_r, down_r, start;
    logic [15:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  mode;
    logic        busy, frame_done;
    int n_tests = 0;
    int n_fail  = 0;

    int m_pl, m_pr, m_x, m_y, m_sl, m_sr, m_mode, m_cnt;
    bit m_dx, m_dy;
    logic [3:0] btn = 4'd0;

    always #5 clk = ~clk;

    pong_frame_sequencer dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .up_l(up_l), .down_l(down_l), .up_r(up_r), .down_r(down_r), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
        .score_l(score_l), .score_r(score_r), .mode(mode), .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [79:0] observed();
        return {6'd0, paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, mode};
    endfunction

    function automatic logic [79:0] expected();
        return {6'd0, 16'(m_pl), 16'(m_pr), 16'(m_x), 16'(m_y), 4'(m_sl), 4'(m_sr), 2'(m_mode)};
    endfunction

    task automatic model_reset();
        m_pl = 296; m_pr = 296; m_x = 632; m_y = 352;
        m_sl = 0; m_sr = 0; m_mode = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
    endtask

    function automatic int step(int y, bit u, bit d);
        if (u && !d) return (y - 8 < 0) ? 0 : y - 8;
        if (d && !u) return (y + 8 > 592) ? 592 : y + 8;
        return y;
    endfunction

    function automatic bit overlap(int y, int p);
        return y + 16 > p && y < p + 128;
    endfunction

    task automatic serve_ball(input bit dx);
        m_x = 632; m_y = 352; m_dx = dx; m_cnt = 60;
        m_mode = (m_sl == 7 || m_sr == 7) ? 3 : 1;
    endtask

    // One whole frame of game rules applied at once.
    task automatic model_frame(input bit ul, input bit dl, input bit ur, input bit dr, input bit st);
        if (m_mode == 1 || m_mode == 2) begin
            m_pl = step(m_pl, ul, dl);
            m_pr = step(m_pr, ur, dr);
        end
        if ((m_mode == 0 || m_mode == 3) && st) begin
            m_sl = 0; m_sr = 0; m_dy = 1;
            serve_ball(1);
        end
        if (m_mode == 2) begin
            m_x += m_dx ? 4 : -4;
            m_y += m_dy ? 4 : -4;
            if (m_y <= 0) begin m_y = 0; m_dy = 1; end
            else if (m_y >= 704) begin m_y = 704; m_dy = 0; end
            if (!m_dx && m_x <= 80 && m_x + 16 > 64 && overlap(m_y, m_pl)) begin
                m_x = 80; m_dx = 1;
            end else if (m_dx && m_x + 16 >= 1200 && m_x < 1216 && overlap(m_y, m_pr)) begin
                m_x = 1184; m_dx = 0;
            end
            if (!m_dx && m_x <= 0) begin m_sr++; serve_ball(0); end
            else if (m_dx && m_x >= 1264) begin m_sl++; serve_ball(1); end
        end else if (m_mode == 1) begin
            m_cnt--;
            if (m_cnt == 0) m_mode = 2;
        end
    endtask

    task automatic frame(input bit do_reset, input bit allow_start);
        logic [79:0] prev;
        bit st, glitch;
        if ($urandom_range(0, 15) == 0) btn = 4'($urandom);
        st     = allow_start && $urandom_range(0, 9) == 0;
        glitch = !do_reset && $urandom_range(0, 3) == 0;
        @(negedge clk);
        {up_l, down_l, up_r, down_r} = btn;
        start = st;
        vsync = 1'b1;
        prev = expected();
        model_frame(btn[3], btn[2], btn[1], btn[0], st);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("busy_update", busy, 1'b1);
            check("frame_done_early", frame_done, 1'b0);
            check("outputs_hold", observed(), prev);
            if (k == 2) vsync = 1'b0;
            if (k == 3 && glitch) vsync = 1'b1;
            if (k == 4) vsync = 1'b0;
            if (k == 3 && do_reset) begin
                reset = 1'b1;
                vsync = 1'b1;
                break;
            end
        end
        if (do_reset) begin
            @(negedge clk);
            model_reset();
            check("midreset_outputs", observed(), expected());
            check("midreset_busy", busy, 1'b0);
            check("midreset_frame_done", frame_done, 1'b0);
            reset = 1'b0;
            repeat (4) begin
                @(negedge clk);
                check("held_vsync_busy", busy, 1'b0);
                check("held_vsync_frame_done", frame_done, 1'b0);
            end
            vsync = 1'b0;
        end else begin
            @(negedge clk);
            check("busy_after_commit", busy, 1'b0);
            check("frame_done_pulse", frame_done, 1'b1);
            check("commit_outputs", observed(), expected());
            @(negedge clk);
            check("frame_done_single", frame_done, 1'b0);
            check("outputs_stable", observed(), expected());
        end
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; start = 1'b0;
        up_l = 1'b0; down_l = 1'b0; up_r = 1'b0; down_r = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", observed(), expected());
        check("reset_busy", busy, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        reset = 1'b0;
        for (int f = 0; f < 2600; f++)
            frame(f == 40 || f == 2400, f >= 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
